// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead output, occupancy count,
// programmable almost-full/almost-empty, synchronous flush and
// write-through-when-full.  All status flags decode from one binary
// occupancy counter.
//
// Optional feature: define SYNC_FIFO_ERR_EN to build sticky overflow and
// underflow error registers behind ovf_o/unf_o.  Without it both ports are
// tied low, so the interface is the same in both builds.
module sync_fifo #(
   parameter int DW        = 8,
   parameter int AW        = 4,
   parameter int AFULL_TH  = 12,
   parameter int AEMPTY_TH = 2
) (
   input  logic          clk,
   input  logic          rst_ni,
   input  logic          clr_i,
   input  logic [DW-1:0] dat_i,
   input  logic          wen,
   input  logic          ren,
   output logic [DW-1:0] dat_o,
   output logic          full,
   output logic          empty,
   output logic          almost_full,
   output logic          almost_empty,
   output logic [AW:0]   count,
   output logic          ovf_o,
   output logic          unf_o
);

   localparam int DEPTH = 1 << AW;

   // Thresholds pre-sized to the counter width so every flag compare is
   // same-width.
   localparam logic [AW:0] DEPTH_CNT  = (AW+1)'(DEPTH);
   localparam logic [AW:0] AFULL_CNT  = (AW+1)'(AFULL_TH);
   localparam logic [AW:0] AEMPTY_CNT = (AW+1)'(AEMPTY_TH);
   localparam logic [AW:0] CNT_ONE    = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   count_q;
   logic          rd_acc;
   logic          wr_acc;

   // Status flags come only from the registered count, so they change in
   // the same cycle as count and never depend on this cycle's requests.
   always_comb begin
      full         = (count_q == DEPTH_CNT);
      empty        = (count_q == '0);
      almost_full  = (count_q >= AFULL_CNT);
      almost_empty = (count_q <= AEMPTY_CNT);
      count        = count_q;
   end

   // Handshake acceptance: a read needs data; a write needs room, or the
   // slot a simultaneous read is freeing when the FIFO is full.
   always_comb begin
      rd_acc = ren & ~empty;
      wr_acc = wen & (~full | rd_acc);
   end

   // Show-ahead output: the head entry is visible with no read latency.
   always_comb begin
      dat_o = mem[rptr];
   end

   // Storage array is never reset; writes are suppressed during reset or
   // flush so a flushed cycle leaves no trace in the queue.
   always_ff @(posedge clk) begin
      if (rst_ni && !clr_i && wr_acc) begin
         mem[wptr] <= dat_i;
      end
   end

   // Pointers and occupancy: reset beats flush, flush beats any request.
   // A simultaneous accepted read and write leaves the count unchanged.
   always_ff @(posedge clk) begin
      if (!rst_ni) begin
         wptr    <= '0;
         rptr    <= '0;
         count_q <= '0;
      end else if (clr_i) begin
         wptr    <= '0;
         rptr    <= '0;
         count_q <= '0;
      end else begin
         if (wr_acc) begin
            wptr <= wptr + PTR_ONE;
         end
         if (rd_acc) begin
            rptr <= rptr + PTR_ONE;
         end
         case ({wr_acc, rd_acc})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

`ifdef SYNC_FIFO_ERR_EN
   logic ovf_q;
   logic unf_q;

   // Sticky error capture: a rejected write raises overflow, a read of an
   // empty FIFO raises underflow; flush clears both and wins over a set.
   always_ff @(posedge clk) begin
      if (!rst_ni) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else if (clr_i) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (wen && !wr_acc) begin
            ovf_q <= 1'b1;
         end
         if (ren && empty) begin
            unf_q <= 1'b1;
         end
      end
   end

   // Error registers drive the ports directly.
   always_comb begin
      ovf_o = ovf_q;
      unf_o = unf_q;
   end
`else
   // Error reporting not built: ports held low.
   always_comb begin
      ovf_o = 1'b0;
      unf_o = 1'b0;
   end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: drives sync_fifo (DEPTH=4, AFULL_TH=3, AEMPTY_TH=1) with
// directed sequences and then random traffic, comparing every output against
// a queue-based reference model after each clock edge.
module tb_sync_fifo;

   localparam int DW        = 8;
   localparam int AW        = 2;
   localparam int DEPTH     = 4;
   localparam int AFULL_TH  = 3;
   localparam int AEMPTY_TH = 1;

`ifdef SYNC_FIFO_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          clk;
   logic          rst_ni;
   logic          clr_i;
   logic [DW-1:0] dat_i;
   logic          wen;
   logic          ren;
   logic [DW-1:0] dat_o;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [AW:0]   count;
   logic          ovf_o;
   logic          unf_o;

   int total_checks;
   int bad_checks;

   // reference model state
   logic [DW-1:0] model_q[$];
   bit            model_ovf;
   bit            model_unf;

   sync_fifo #(
      .DW(DW), .AW(AW), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
   ) dut (
      .clk(clk), .rst_ni(rst_ni), .clr_i(clr_i), .dat_i(dat_i),
      .wen(wen), .ren(ren), .dat_o(dat_o), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .ovf_o(ovf_o), .unf_o(unf_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total_checks++;
      if (observed !== expected) begin
         bad_checks++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   // Advance the model by one clock edge from the FIFO's queue semantics.
   task automatic updateModel(input bit r, input bit c, input bit w_en,
                              input bit r_en, input logic [DW-1:0] d);
      bit rd;
      bit wr;
      rd = r_en && (model_q.size() > 0);
      wr = w_en && ((model_q.size() < DEPTH) || rd);
      if (!r || c) begin
         model_q.delete();
         model_ovf = 1'b0;
         model_unf = 1'b0;
      end else begin
         if (w_en && !wr) model_ovf = 1'b1;
         if (r_en && model_q.size() == 0) model_unf = 1'b1;
         if (rd) void'(model_q.pop_front());
         if (wr) model_q.push_back(d);
      end
   endtask

   task automatic checkAll(input string tag);
      int n;
      n = model_q.size();
      checkOutput({tag, ":count"}, 32'(count), 32'(n));
      checkOutput({tag, ":empty"}, 32'(empty), 32'(n == 0));
      checkOutput({tag, ":full"}, 32'(full), 32'(n == DEPTH));
      checkOutput({tag, ":afull"}, 32'(almost_full), 32'(n >= AFULL_TH));
      checkOutput({tag, ":aempty"}, 32'(almost_empty), 32'(n <= AEMPTY_TH));
      checkOutput({tag, ":ovf"}, 32'(ovf_o), 32'(ERR_EN & model_ovf));
      checkOutput({tag, ":unf"}, 32'(unf_o), 32'(ERR_EN & model_unf));
      if (n > 0) checkOutput({tag, ":dat"}, 32'(dat_o), 32'(model_q[0]));
   endtask

   // One clock cycle: drive on the falling edge, step the model at the
   // rising edge, then compare 1ns later.
   task automatic applyStimulus(input string tag, input bit r, input bit c,
                                input bit w_en, input bit r_en,
                                input logic [DW-1:0] d);
      @(negedge clk);
      rst_ni = r;
      clr_i  = c;
      wen    = w_en;
      ren    = r_en;
      dat_i  = d;
      @(posedge clk);
      updateModel(r, c, w_en, r_en, d);
      #1;
      checkAll(tag);
   endtask

   initial begin
      logic [DW-1:0] rd_byte;
      total_checks = 0;
      bad_checks   = 0;
      model_ovf    = 1'b0;
      model_unf    = 1'b0;
      rst_ni = 1'b0;
      clr_i  = 1'b0;
      wen    = 1'b0;
      ren    = 1'b0;
      dat_i  = '0;

      // reset and fill
      applyStimulus("rst0", 0, 0, 0, 0, 8'h00);
      applyStimulus("rst1", 0, 0, 0, 0, 8'h00);
      applyStimulus("idle", 1, 0, 0, 0, 8'h00);
      for (int i = 0; i < 4; i++) begin
         applyStimulus("fill", 1, 0, 1, 0, 8'hA1 + 8'(i));
         checkOutput("fill_head", 32'(dat_o), 32'h A1);
      end
      checkOutput("fill_full", 32'(full), 32'd1);

      // drain
      for (int i = 0; i < 4; i++) applyStimulus("drain", 1, 0, 0, 1, 8'h00);
      checkOutput("drain_empty", 32'(empty), 32'd1);

      // full with simultaneous write and read
      for (int i = 0; i < 4; i++) applyStimulus("refill", 1, 0, 1, 0, 8'hA1 + 8'(i));
      applyStimulus("wthru", 1, 0, 1, 1, 8'hB5);
      checkOutput("wthru_head", 32'(dat_o), 32'h A2);
      for (int i = 0; i < 3; i++) applyStimulus("wthru_drain", 1, 0, 0, 1, 8'h00);
      checkOutput("wthru_last", 32'(dat_o), 32'h B5);
      applyStimulus("wthru_drain", 1, 0, 0, 1, 8'h00);

      // overflow / underflow then flush
      for (int i = 0; i < 4; i++) applyStimulus("ofill", 1, 0, 1, 0, 8'h10 + 8'(i));
      applyStimulus("ovf", 1, 0, 1, 0, 8'hEE);
      for (int i = 0; i < 4; i++) applyStimulus("odrain", 1, 0, 0, 1, 8'h00);
      applyStimulus("unf", 1, 0, 0, 1, 8'h00);
      applyStimulus("clr", 1, 1, 0, 0, 8'h00);

      // flush overrides simultaneous write and read
      applyStimulus("c2a", 1, 0, 1, 0, 8'h21);
      applyStimulus("c2b", 1, 0, 1, 0, 8'h22);
      applyStimulus("clr_wr", 1, 1, 1, 1, 8'h99);
      applyStimulus("post_clr", 1, 0, 1, 0, 8'hC7);
      checkOutput("post_clr_dat", 32'(dat_o), 32'h C7);

      // reset mid-write, then wrap
      applyStimulus("r3a", 1, 0, 1, 0, 8'h31);
      applyStimulus("r3b", 1, 0, 1, 0, 8'h32);
      applyStimulus("mid_rst", 0, 0, 1, 0, 8'h33);
      applyStimulus("after_rst", 1, 0, 0, 0, 8'h00);
      for (int i = 0; i < 10; i++) begin
         applyStimulus("wrap_w", 1, 0, 1, 0, 8'h50 + 8'(i));
         applyStimulus("wrap_r", 1, 0, 0, 1, 8'h00);
      end

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         bit r;
         bit c;
         r = ($urandom_range(0, 99) != 0);
         c = ($urandom_range(0, 39) == 0);
         rd_byte = 8'($urandom);
         applyStimulus("rand", r, c, 1'($urandom), 1'($urandom), rd_byte);
      end

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
